// File: rtl/uart_rx_fe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx_fe                                                |
// | Brief    : UART receive front end: synchroniser, 3-sample majority   |
// |            vote, framing/parity/overrun flags, break, ready/valid.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx_fe #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0,
    parameter int CLKS_PER_BIT = 1250,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_pw   = $clog2(CLKS_PER_BIT);
    localparam int c_half = CLKS_PER_BIT / 2;

    // Phase within the current bit; bit centre sits at c_half.
    localparam logic [c_pw-1:0] c_ph_v0   = c_pw'(c_half - 1);
    localparam logic [c_pw-1:0] c_ph_v1   = c_pw'(c_half);
    localparam logic [c_pw-1:0] c_ph_v2   = c_pw'(c_half + 1);
    localparam logic [c_pw-1:0] c_ph_dec  = c_pw'(c_half + 2);
    localparam logic [c_pw-1:0] c_ph_last = c_pw'(CLKS_PER_BIT - 1);

    localparam logic [3:0] c_last_data = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_par   = 3'd3;
    localparam logic [2:0] c_st_stop  = 3'd4;
    localparam logic [2:0] c_st_break = 3'd5;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_line;
    logic [2:0]             r_state;
    logic [c_pw-1:0]        r_phase;
    logic [3:0]             r_bit;
    logic [2:0]             r_vote;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parx;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   w_maj;
    logic                   w_dec;
    logic                   w_deliver;
    logic                   w_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], data_in};
        end
    end

    assign w_line    = r_sync[SYNC_STAGES-1];
    assign w_maj     = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_vote[2]) | (r_vote[1] & r_vote[2]);
    assign w_dec     = (r_phase == c_ph_dec) && (r_state != c_st_idle) && (r_state != c_st_break);
    assign w_deliver = w_dec && (r_state == c_st_stop) && (r_bit == c_last_stop);
    assign w_hs      = valid & ready;
    assign busy      = (r_state != c_st_idle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_phase <= '0;
            r_bit   <= '0;
            r_vote  <= '0;
            r_shift <= '0;
            r_parx  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (r_state == c_st_idle || r_state == c_st_break || r_phase == c_ph_last) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end

            if (r_phase == c_ph_v0 || r_phase == c_ph_v1 || r_phase == c_ph_v2) begin
                r_vote <= {r_vote[1:0], w_line};
            end

            case (r_state)
                c_st_idle: begin
                    r_bit  <= '0;
                    r_parx <= 1'b0;
                    r_perr <= 1'b0;
                    r_ferr <= 1'b0;
                    // The detection cycle itself is c = 0, so the next one is c = 1.
                    if (!w_line) begin
                        r_state <= c_st_start;
                        r_phase <= c_pw'(1);
                    end
                end
                c_st_start: begin
                    if (w_dec) begin
                        r_state <= w_maj ? c_st_idle : c_st_data;
                    end
                end
                c_st_data: begin
                    if (w_dec) begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_parx  <= r_parx ^ w_maj;
                        if (r_bit == c_last_data) begin
                            r_bit   <= '0;
                            r_state <= (PARITY != 0) ? c_st_par : c_st_stop;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end
                c_st_par: begin
                    if (w_dec) begin
                        r_perr  <= (PARITY == 1) ? ~(r_parx ^ w_maj) : (r_parx ^ w_maj);
                        r_state <= c_st_stop;
                    end
                end
                c_st_stop: begin
                    if (w_dec) begin
                        r_ferr <= r_ferr | ~w_maj;
                        if (r_bit == c_last_stop) begin
                            r_bit   <= '0;
                            r_state <= (r_ferr | ~w_maj) ? c_st_break : c_st_idle;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end
                c_st_break: begin
                    // A held-low line produces one errored word, then waits here.
                    if (w_line) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_deliver) begin
            data_out   <= r_shift;
            parity_err <= r_perr;
            frame_err  <= r_ferr | ~w_maj;
            valid      <= 1'b1;
            // A word still pending and not taken this cycle is lost.
            overrun    <= valid & ~ready;
        end else if (w_hs) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fe.sv
`default_nettype none
// Directed bench for uart_rx_fe: one no-parity and one even-parity instance.
module tb_uart_rx_fe;

    localparam int c_cpb = 16;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic tx    = 1'b1;
    logic ready = 1'b1;
    int   sel   = 0;

    logic       w_rx0, w_rx1;
    logic [7:0] w_data0, w_data1;
    logic       w_valid0, w_valid1, w_pe0, w_pe1, w_fe0, w_fe1;
    logic       w_ov0, w_ov1, w_busy0, w_busy1;

    assign w_rx0 = (sel == 0) ? tx : 1'b1;
    assign w_rx1 = (sel == 1) ? tx : 1'b1;

    uart_rx_fe #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .CLKS_PER_BIT(c_cpb), .SYNC_STAGES(2)) u_rx0 (
        .clk(clk), .rst(rst), .data_in(w_rx0), .data_out(w_data0), .valid(w_valid0), .ready(ready),
        .parity_err(w_pe0), .frame_err(w_fe0), .overrun(w_ov0), .busy(w_busy0));

    uart_rx_fe #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2), .CLKS_PER_BIT(c_cpb), .SYNC_STAGES(2)) u_rx1 (
        .clk(clk), .rst(rst), .data_in(w_rx1), .data_out(w_data1), .valid(w_valid1), .ready(ready),
        .parity_err(w_pe1), .frame_err(w_fe1), .overrun(w_ov1), .busy(w_busy1));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_start = 0;
    int rise0 = 0;
    int n0 = 0, n1 = 0;
    logic p0 = 1'b0;
    logic [7:0] l0_data = '0, l1_data = '0;
    logic l0_pe = 1'b0, l0_fe = 1'b0, l0_ov = 1'b0, l1_pe = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    // Records every presented word (valid-high cycle) of both instances.
    always @(negedge clk) begin
        if (w_valid0) begin
            if (!p0) rise0 = cyc;
            n0 = n0 + 1;
            l0_data = w_data0;
            l0_pe = w_pe0;
            l0_fe = w_fe0;
            l0_ov = w_ov0;
        end
        p0 = w_valid0;
        if (w_valid1) begin
            n1 = n1 + 1;
            l1_data = w_data1;
            l1_pe = w_pe1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        tx = b;
        repeat (c_cpb) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        tx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic pbit, input logic stopb);
        logic [7:0] v;
        v = d;
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        if (par_en) drive_bit(pbit);
        drive_bit(stopb);
    endtask

    initial begin
        int n_ref;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(w_valid0), 32'd0);
        check("rst_busy", 32'(w_busy0), 32'd0);
        check("rst_data", 32'(w_data0), 32'h00);
        check("rst_perr", 32'(w_pe0), 32'd0);
        check("rst_ferr", 32'(w_fe0), 32'd0);
        check("rst_ovr", 32'(w_ov0), 32'd0);
        @(posedge clk);
        #1;
        idle(4);

        // Basic frame and latency from the pin edge
        n_ref = n0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("a5_count", 32'(n0 - n_ref), 32'd1);
        check("a5_latency", 32'(rise0 - t_start), 32'd157);
        check("a5_data", 32'(l0_data), 32'hA5);
        check("a5_perr", 32'(l0_pe), 32'd0);
        check("a5_ferr", 32'(l0_fe), 32'd0);
        check("a5_ovr", 32'(l0_ov), 32'd0);

        // Glitch rejection: 4 low cycles, start decision at c = 10
        n_ref = n0;
        tx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tx = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_c10", 32'(w_busy0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("glitch_busy_c11", 32'(w_busy0), 32'd0);
        @(posedge clk);
        #1;
        idle(40);
        check("glitch_novalid", 32'(n0 - n_ref), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("3c_data", 32'(l0_data), 32'h3C);
        check("3c_count", 32'(n0 - n_ref), 32'd1);

        // Even parity instance
        sel = 1;
        n_ref = n1;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(8);
        check("par_ok_data", 32'(l1_data), 32'h07);
        check("par_ok_perr", 32'(l1_pe), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        idle(8);
        check("par_bad_data", 32'(l1_data), 32'h07);
        check("par_bad_perr", 32'(l1_pe), 32'd1);
        check("par_count", 32'(n1 - n_ref), 32'd2);
        sel = 0;
        idle(8);

        // Frame error followed by a held-low line
        n_ref = n0;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        tx = 1'b0;
        repeat (5 * c_cpb) @(posedge clk);
        @(negedge clk);
        check("brk_count", 32'(n0 - n_ref), 32'd1);
        check("brk_ferr", 32'(l0_fe), 32'd1);
        check("brk_data", 32'(l0_data), 32'h81);
        check("brk_busy", 32'(w_busy0), 32'd1);
        @(posedge clk);
        #1;
        idle(40);
        check("brk_count_after", 32'(n0 - n_ref), 32'd1);
        check("brk_busy_after", 32'(w_busy0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("post_brk_data", 32'(l0_data), 32'h5A);
        check("post_brk_ferr", 32'(l0_fe), 32'd0);

        // Overrun under backpressure
        ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("ovr_first_data", 32'(w_data0), 32'h11);
        check("ovr_first_ovr", 32'(w_ov0), 32'd0);
        idle(24);
        check("ovr_hold_valid", 32'(w_valid0), 32'd1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("ovr_valid", 32'(w_valid0), 32'd1);
        check("ovr_data", 32'(w_data0), 32'h22);
        check("ovr_flag", 32'(w_ov0), 32'd1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_clr_valid", 32'(w_valid0), 32'd0);
        check("ovr_clr_flag", 32'(w_ov0), 32'd0);
        idle(8);

        // Reset in the middle of data bit 3 of 0x55
        n_ref = n0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        tx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        tx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(40);
        check("rst_mid_valid", 32'(w_valid0), 32'd0);
        check("rst_mid_busy", 32'(w_busy0), 32'd0);
        check("rst_mid_count", 32'(n0 - n_ref), 32'd0);
        send_frame(8'h66, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("post_rst_data", 32'(l0_data), 32'h66);
        check("post_rst_count", 32'(n0 - n_ref), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
